// File: rtl/dmem_bus_master_pkg.sv
// Shared definitions for the data-memory bus master: SIZE codes, funct3
// constants, FSM states, request/response structs and decode helpers.
package dmem_bus_master_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
    logic        err;
  } mem_rsp_t;

  // Legal funct3 for the direction and naturally aligned for the access size.
  function automatic logic req_legal(input logic write, input logic [2:0] f3,
                                     input logic [1:0] a);
    logic ok;
    ok = 1'b0;
    if (write) begin
      case (f3)
        F3_SB:   ok = 1'b1;
        F3_SH:   ok = ~a[0];
        F3_SW:   ok = (a == 2'b00);
        default: ok = 1'b0;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: ok = 1'b1;
        F3_LH, F3_LHU: ok = ~a[0];
        F3_LW:         ok = (a == 2'b00);
        default:       ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

  // funct3[1:0] -> bus SIZE code.
  function automatic logic [1:0] size_code(input logic [2:0] f3);
    logic [1:0] sz;
    case (f3[1:0])
      2'b10:   sz = SZ_WORD;
      2'b01:   sz = SZ_HALF;
      default: sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  // Store data stays right-justified; unused upper bits are zeroed.
  function automatic logic [31:0] store_fmt(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3[1:0])
      2'b10:   d = wd;
      2'b01:   d = {16'h0, wd[15:0]};
      default: d = {24'h0, wd[7:0]};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dmem_bus_master_if.sv
// MEM-stage handshake plus the non-tristate data-bus pins. DDT stays a
// plain inout on the top so the tri-state driver is a simple module port.
interface dmem_bus_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic        ACKD_n;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, ACKD_n,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy, DAD, MREQ, WRITE, SIZE
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, ACKD_n,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy, DAD, MREQ, WRITE, SIZE
  );
endinterface

// File: rtl/dmem_load_ext.sv
// Load extender: picks the right-justified byte/half/word from the raw
// bus word and sign- or zero-extends it according to funct3.
module dmem_load_ext
  import dmem_bus_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // Upper raw bits are ignored for sub-word loads.
  always_comb begin
    data = raw;
    case (funct3)
      F3_LB:   data = {{24{raw[7]}}, raw[7:0]};
      F3_LBU:  data = {24'h0, raw[7:0]};
      F3_LH:   data = {{16{raw[15]}}, raw[15:0]};
      F3_LHU:  data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/dmem_bus_master.sv
// Data-memory bus initiator: one load/store at a time from the MEM stage,
// holds the bus until ACKD_n or timeout, returns extended load data.
module dmem_bus_master
  import dmem_bus_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  dmem_bus_master_if.master  bus,
  inout  wire  [31:0]        DDT
);

  // Counter only needs to reach TIMEOUT_CYCLES-1 before the abort edge.
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t      state_q, state_nx;
  mem_req_t    req;
  mem_rsp_t    rsp_q;
  logic [31:0] dad_q, wdata_q, ld_data;
  logic        write_q;
  logic [1:0]  size_q;
  logic [2:0]  f3_q;
  logic [CW-1:0] to_cnt_q;
  logic        legal, accept, in_req, acked, to_hit, done, drv;

  assign req    = '{write: bus.req_write, funct3: bus.req_funct3,
                    addr: bus.req_addr, wdata: bus.req_wdata};
  assign legal  = req_legal(req.write, req.funct3, req.addr[1:0]);
  assign accept = (state_q == ST_IDLE) && bus.req_valid;
  assign in_req = (state_q == ST_REQ);
  // ACKD_n only has meaning while MREQ is up, i.e. in REQ.
  assign acked  = in_req && !bus.ACKD_n;
  assign to_hit = (TIMEOUT_CYCLES != 0) && (32'(to_cnt_q) == TIMEOUT_CYCLES - 1);
  assign done   = in_req && (!bus.ACKD_n || to_hit);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nx;
  end

  // Next state: illegal requests skip the bus and go straight to RESP.
  always_comb begin
    state_nx = state_q;
    case (state_q)
      ST_IDLE: if (bus.req_valid) state_nx = legal ? ST_REQ : ST_RESP;
      ST_REQ:  if (!bus.ACKD_n || to_hit) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus address/control/store-data registers, loaded on a legal accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dad_q   <= '0;
      write_q <= 1'b0;
      size_q  <= SZ_WORD;
      wdata_q <= '0;
      f3_q    <= '0;
    end else if (accept && legal) begin
      dad_q   <= req.addr;
      write_q <= req.write;
      size_q  <= size_code(req.funct3);
      wdata_q <= store_fmt(req.funct3, req.wdata);
      f3_q    <= req.funct3;
    end else if (done) begin
      write_q <= 1'b0;
    end
  end

  // Wait counter: cleared on accept, counts REQ edges without acknowledge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    to_cnt_q <= '0;
    else if (accept)               to_cnt_q <= '0;
    else if (in_req && bus.ACKD_n) to_cnt_q <= to_cnt_q + CW'(1);
  end

  dmem_load_ext u_ext (
    .funct3 (f3_q),
    .raw    (DDT),
    .data   (ld_data)
  );

  // Response register: one-cycle pulse; ack on the timeout edge still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q <= '0;
    end else begin
      rsp_q.valid <= 1'b0;
      if (accept && !legal) begin
        rsp_q <= '{valid: 1'b1, rdata: 32'h0, err: 1'b1};
      end else if (done) begin
        rsp_q.valid <= 1'b1;
        rsp_q.err   <= !acked;
        rsp_q.rdata <= (acked && !write_q) ? ld_data : 32'h0;
      end
    end
  end

  assign drv = in_req && write_q;
  assign DDT = drv ? wdata_q : 'z;

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.MREQ      = in_req;
  assign bus.WRITE     = write_q;
  assign bus.SIZE      = size_q;
  assign bus.DAD       = dad_q;
  assign bus.rsp_valid = rsp_q.valid;
  assign bus.rsp_rdata = rsp_q.rdata;
  assign bus.rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_dmem_bus_master.sv
// Directed bench for dmem_bus_master; the bench plays the memory side.
module tb_dmem_bus_master;
  localparam logic [31:0] PAT = 32'h5555_AAAA;

  logic        clk, rst_n;
  logic [31:0] mem_ddt;
  logic        mem_oe;
  wire  [31:0] DDT;
  int          errors, checks;

  dmem_bus_master_if bif ();

  dmem_bus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif),
    .DDT   (DDT)
  );

  // Memory drives DDT whenever the master is not driving a store.
  assign mem_oe = !(bif.MREQ && bif.WRITE);
  assign DDT    = mem_oe ? mem_ddt : 32'bz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request for one edge; returns at the negedge after the accept.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    bif.req_valid  = 1'b1;
    bif.req_write  = w;
    bif.req_funct3 = f3;
    bif.req_addr   = a;
    bif.req_wdata  = wd;
    @(negedge clk);
    bif.req_valid  = 1'b0;
  endtask

  // Load acknowledged in its first MREQ cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [1:0] sz, input logic [31:0] raw, input logic [31:0] exp);
    chk({tag, "_ready"}, 32'(bif.req_ready), 32'd1);
    issue(1'b0, f3, a, 32'h0);
    chk({tag, "_mreq"}, 32'(bif.MREQ), 32'd1);
    chk({tag, "_write"}, 32'(bif.WRITE), 32'd0);
    chk({tag, "_size"}, 32'(bif.SIZE), 32'(sz));
    chk({tag, "_dad"}, bif.DAD, a);
    chk({tag, "_rv0"}, 32'(bif.rsp_valid), 32'd0);
    mem_ddt = raw;
    bif.ACKD_n = 1'b0;
    @(negedge clk);
    bif.ACKD_n = 1'b1;
    mem_ddt = PAT;
    chk({tag, "_mreq_drop"}, 32'(bif.MREQ), 32'd0);
    chk({tag, "_rv"}, 32'(bif.rsp_valid), 32'd1);
    chk({tag, "_rdata"}, bif.rsp_rdata, exp);
    chk({tag, "_err"}, 32'(bif.rsp_err), 32'd0);
    @(negedge clk);
    chk({tag, "_rv_end"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, "_busy_end"}, 32'(bif.busy), 32'd0);
  endtask

  // Illegal request: no bus cycle, error response on the edge after accept.
  task automatic do_err(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a);
    issue(w, f3, a, 32'hFFFF_FFFF);
    chk({tag, "_mreq"}, 32'(bif.MREQ), 32'd0);
    chk({tag, "_rv"}, 32'(bif.rsp_valid), 32'd1);
    chk({tag, "_err"}, 32'(bif.rsp_err), 32'd1);
    chk({tag, "_rdata"}, bif.rsp_rdata, 32'h0);
    @(negedge clk);
    chk({tag, "_rv_end"}, 32'(bif.rsp_valid), 32'd0);
    chk({tag, "_mreq_end"}, 32'(bif.MREQ), 32'd0);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    mem_ddt = PAT;
    bif.req_valid = 1'b0;
    bif.req_write = 1'b0;
    bif.req_funct3 = 3'b0;
    bif.req_addr = 32'h0;
    bif.req_wdata = 32'h0;
    bif.ACKD_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_mreq", 32'(bif.MREQ), 32'd0);
    chk("rst_write", 32'(bif.WRITE), 32'd0);
    chk("rst_size", 32'(bif.SIZE), 32'd0);
    chk("rst_dad", bif.DAD, 32'h0);
    chk("rst_rv", 32'(bif.rsp_valid), 32'd0);
    chk("rst_rdata", bif.rsp_rdata, 32'h0);
    chk("rst_err", 32'(bif.rsp_err), 32'd0);
    chk("rst_busy", 32'(bif.busy), 32'd0);
    chk("rst_ddt", DDT, PAT);
    rst_n = 1'b1;
    @(negedge clk);

    // Loads with extension
    do_load("lw",  3'b010, 32'h8000_0000, 2'b00, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    do_load("lb",  3'b000, 32'h8000_0003, 2'b10, 32'hAAAA_AAF0, 32'hFFFF_FFF0);
    do_load("lbu", 3'b100, 32'h8000_0003, 2'b10, 32'hAAAA_AAF0, 32'h0000_00F0);
    do_load("lh",  3'b001, 32'h8000_0002, 2'b01, 32'h1234_8001, 32'hFFFF_8001);
    do_load("lhu", 3'b101, 32'h8000_0002, 2'b01, 32'h1234_8001, 32'h0000_8001);

    // SB to stdout address: right-justified byte, release after ack
    issue(1'b1, 3'b000, 32'hF000_0000, 32'h1234_5641);
    chk("sb_mreq", 32'(bif.MREQ), 32'd1);
    chk("sb_size", 32'(bif.SIZE), 32'd2);
    chk("sb_write", 32'(bif.WRITE), 32'd1);
    chk("sb_dad", bif.DAD, 32'hF000_0000);
    chk("sb_ddt", DDT, 32'h0000_0041);
    bif.ACKD_n = 1'b0;
    @(negedge clk);
    bif.ACKD_n = 1'b1;
    chk("sb_mreq_drop", 32'(bif.MREQ), 32'd0);
    chk("sb_write_drop", 32'(bif.WRITE), 32'd0);
    chk("sb_ddt_rel", DDT, PAT);
    chk("sb_rv", 32'(bif.rsp_valid), 32'd1);
    chk("sb_rdata", bif.rsp_rdata, 32'h0);
    chk("sb_err", 32'(bif.rsp_err), 32'd0);
    @(negedge clk);

    // SH: halfword zero-padded
    issue(1'b1, 3'b001, 32'h8000_0006, 32'hABCD_1234);
    chk("sh_size", 32'(bif.SIZE), 32'd1);
    chk("sh_ddt", DDT, 32'h0000_1234);
    bif.ACKD_n = 1'b0;
    @(negedge clk);
    bif.ACKD_n = 1'b1;
    chk("sh_rv", 32'(bif.rsp_valid), 32'd1);
    @(negedge clk);

    // Three wait edges, ack on the 4th (also the edge the timeout would fire)
    issue(1'b0, 3'b001, 32'h8000_0002, 32'h0);
    bif.req_valid = 1'b1;
    bif.req_addr = 32'h1111_1110;
    for (int i = 0; i < 4; i++) begin
      chk("wait_mreq", 32'(bif.MREQ), 32'd1);
      chk("wait_dad", bif.DAD, 32'h8000_0002);
      chk("wait_size", 32'(bif.SIZE), 32'd1);
      chk("wait_ready", 32'(bif.req_ready), 32'd0);
      chk("wait_rv", 32'(bif.rsp_valid), 32'd0);
      if (i == 3) begin
        bif.req_valid = 1'b0;
        bif.ACKD_n = 1'b0;
        mem_ddt = 32'hFFFF_7FFE;
      end
      @(negedge clk);
    end
    bif.ACKD_n = 1'b1;
    mem_ddt = PAT;
    chk("wait_rv_end", 32'(bif.rsp_valid), 32'd1);
    chk("wait_err", 32'(bif.rsp_err), 32'd0);
    chk("wait_rdata", bif.rsp_rdata, 32'h0000_7FFE);
    chk("wait_mreq_end", 32'(bif.MREQ), 32'd0);
    @(negedge clk);

    // Timeout after 4 edges without ack
    issue(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to_mreq", 32'(bif.MREQ), 32'd1);
      chk("to_rv", 32'(bif.rsp_valid), 32'd0);
      @(negedge clk);
    end
    chk("to_mreq_drop", 32'(bif.MREQ), 32'd0);
    chk("to_rv_end", 32'(bif.rsp_valid), 32'd1);
    chk("to_err", 32'(bif.rsp_err), 32'd1);
    chk("to_rdata", bif.rsp_rdata, 32'h0);
    @(negedge clk);

    // Illegal requests while memory holds ACKD_n low
    bif.ACKD_n = 1'b0;
    do_err("lw_mis", 1'b0, 3'b010, 32'h8000_0002);
    do_err("ld_f3_011", 1'b0, 3'b011, 32'h8000_0000);
    do_err("sh_mis", 1'b1, 3'b001, 32'h8000_0001);
    do_err("st_f3_100", 1'b1, 3'b100, 32'h8000_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_ack_rv", 32'(bif.rsp_valid), 32'd0);
      chk("idle_ack_mreq", 32'(bif.MREQ), 32'd0);
    end
    bif.ACKD_n = 1'b1;

    // Reset while a store is on the bus
    issue(1'b1, 3'b010, 32'h8000_0020, 32'hCAFE_F00D);
    chk("rstm_ddt_pre", DDT, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    chk("rstm_mreq", 32'(bif.MREQ), 32'd0);
    chk("rstm_write", 32'(bif.WRITE), 32'd0);
    chk("rstm_ddt", DDT, PAT);
    chk("rstm_busy", 32'(bif.busy), 32'd0);
    @(negedge clk);
    chk("rstm_rv", 32'(bif.rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstm_rv2", 32'(bif.rsp_valid), 32'd0);
    do_load("post_rst_lw", 3'b010, 32'h8000_0004, 2'b00, 32'h0123_4567, 32'h0123_4567);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
